// File: rtl/pipe_pkg.sv
// Shared definitions for the issue controller in front of the 4-stage
// regbank/ALU/memory pipeline.
package pipe_pkg;
    localparam int REG_W    = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int PIPE_LAT = 3;

    localparam logic [REG_W-1:0] ADD  = 4'd0;
    localparam logic [REG_W-1:0] SUB  = 4'd1;
    localparam logic [REG_W-1:0] MUL  = 4'd2;
    localparam logic [REG_W-1:0] SEL  = 4'd3;
    localparam logic [REG_W-1:0] AND  = 4'd4;
    localparam logic [REG_W-1:0] OR   = 4'd5;
    localparam logic [REG_W-1:0] XOR  = 4'd6;
    localparam logic [REG_W-1:0] NEGA = 4'd7;
    localparam logic [REG_W-1:0] NEGB = 4'd8;
    localparam logic [REG_W-1:0] SRA  = 4'd9;
    localparam logic [REG_W-1:0] SRL  = 4'd10;
    localparam logic [REG_W-1:0] SLA  = 4'd11;
    localparam logic [REG_W-1:0] FUNC_MAX = SLA;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    function automatic logic func_legal(input logic [REG_W-1:0] f);
        return f <= FUNC_MAX;
    endfunction
endpackage

// File: rtl/pipe_issue_fifo.sv
// Instruction queue ahead of the issue stage; flush empties it in one edge.
module pipe_issue_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  instr_t                 din,
    output instr_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    instr_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; count/pointers define what is valid.
    always_ff @(posedge clk1) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: queues instructions, holds the FIFO head while it reads a
// register still being produced by one of the two most recent issues.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              flush,
    output logic              iss_valid,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    output logic [REG_W-1:0]  iss_rd,
    output logic [REG_W-1:0]  iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic              retire,
    output logic              busy,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_cnt
);
    instr_t                 in_ins, head, iss_q;
    logic                   full, empty;
    logic [$clog2(DEPTH):0] count;
    logic                   accept, legal, push, hazard, issue, stall;
    logic [REG_W-1:0]       sb_rd;
    logic                   sb_valid;
    logic [PIPE_LAT:1]      vld_pipe;

    assign in_ins   = {in_rs1, in_rs2, in_rd, in_func, in_addr};
    assign in_ready = !full && !flush;
    assign accept   = in_valid && in_ready;
    assign legal    = func_legal(in_func);
    assign push     = accept && legal;

    pipe_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .flush (flush),
        .din   (in_ins),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // rd lands at end of t+2, so the issuing and the previous instruction
    // are the only producers a new reader can still race.
    assign hazard = (iss_valid && (head.rs1 == iss_q.rd || head.rs2 == iss_q.rd)) ||
                    (sb_valid  && (head.rs1 == sb_rd    || head.rs2 == sb_rd));
    assign issue  = !empty && !hazard && !flush;
    assign stall  = !empty &&  hazard && !flush;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_q     <= '0;
            sb_rd     <= '0;
            sb_valid  <= 1'b0;
            vld_pipe  <= '0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            iss_valid <= issue;
            if (issue) iss_q <= head;
            sb_rd     <= iss_q.rd;
            sb_valid  <= iss_valid;
            vld_pipe  <= {vld_pipe[PIPE_LAT-1:1], iss_valid};
            illegal   <= accept && !legal;
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign iss_rs1  = iss_q.rs1;
    assign iss_rs2  = iss_q.rs2;
    assign iss_rd   = iss_q.rd;
    assign iss_func = iss_q.func;
    assign iss_addr = iss_q.addr;
    assign retire   = vld_pipe[PIPE_LAT];
    assign busy     = (count != '0) || iss_valid || (|vld_pipe);
endmodule
